// File: rtl/aemb_mul_arb.sv
// Two-thread arbiter for a shared 2-stage multiplier: round-robin issue, tag
// pipeline that mirrors the multiplier stages, and per-thread result capture.
module aemb_mul_arb #(
   parameter int MUL = 1
) (
   input  logic        gclk,
   input  logic        grst,
   input  logic        gena,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   output logic        gnt0,
   output logic        gnt1,
   output logic [31:0] m_opa,
   output logic [31:0] m_opb,
   input  logic [31:0] m_mul,
   output logic        done0,
   output logic        done1,
   output logic [31:0] res0,
   output logic [31:0] res1,
   output logic        busy
);

   logic        run;
   logic        prio_q, prio_d;
   logic        v1_q, v1_d, t1_q, t1_d;
   logic        v2_q, v2_d, t2_q, t2_d;
   logic [1:0]  done_w;
   logic [31:0] prod;

   assign run  = gena & grst;
   assign prod = (MUL != 0) ? m_mul : 32'h0;

   always_ff @(posedge gclk) begin
      if (!grst) begin
         prio_q <= 1'b0;
         v1_q   <= 1'b0;
         t1_q   <= 1'b0;
         v2_q   <= 1'b0;
         t2_q   <= 1'b0;
      end else begin
         prio_q <= prio_d;
         v1_q   <= v1_d;
         t1_q   <= t1_d;
         v2_q   <= v2_d;
         t2_q   <= t2_d;
      end
   end

   // prio names the thread that wins the next tie; it flips away from each winner
   always_comb begin
      gnt0   = run & req0 & (~req1 | ~prio_q);
      gnt1   = run & req1 & (~req0 | prio_q);
      prio_d = prio_q;
      if (gnt0)
         prio_d = 1'b1;
      else if (gnt1)
         prio_d = 1'b0;
      v1_d = v1_q;
      t1_d = t1_q;
      v2_d = v2_q;
      t2_d = t2_q;
      if (gena) begin
         v1_d = gnt0 | gnt1;
         t1_d = gnt1;
         v2_d = v1_q;
         t2_d = t1_q;
      end
   end

   always_comb begin
      m_opa = 32'h0;
      m_opb = 32'h0;
      if (gnt0) begin
         m_opa = a0;
         m_opb = b0;
      end else if (gnt1) begin
         m_opa = a1;
         m_opb = b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_thr
         logic [31:0] res_q;
         assign done_w[gi] = run & v2_q & (t2_q == 1'(gi));
         always_ff @(posedge gclk) begin
            if (!grst)
               res_q <= 32'h0;
            else if (done_w[gi])
               res_q <= prod;
         end
      end
   endgenerate

   assign done0 = done_w[0];
   assign done1 = done_w[1];
   assign res0  = g_thr[0].res_q;
   assign res1  = g_thr[1].res_q;
   // gated so stale tags cannot show during the first reset cycle
   assign busy  = grst & (v1_q | v2_q);

endmodule

// File: tb/tb_aemb_mul_arb.sv
// Directed bench for aemb_mul_arb: one MUL=1 and one MUL=0 instance, each fed
// by its own 2-stage multiplier model, sharing the same stimulus.
module tb_aemb_mul_arb;

   logic        gclk = 1'b0;
   logic        grst, gena, req0, req1;
   logic [31:0] a0, b0, a1, b1;

   logic        gnt0, gnt1, done0, done1, busy;
   logic [31:0] m_opa, m_opb, res0, res1, p1, p2;
   logic        z_gnt0, z_gnt1, z_done0, z_done1, z_busy;
   logic [31:0] z_opa, z_opb, z_res0, z_res1, zp1, zp2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 gclk = ~gclk;

   aemb_mul_arb #(.MUL(1)) u_dut (
      .gclk(gclk), .grst(grst), .gena(gena), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
      .m_opa(m_opa), .m_opb(m_opb), .m_mul(p2), .done0(done0), .done1(done1),
      .res0(res0), .res1(res1), .busy(busy));

   aemb_mul_arb #(.MUL(0)) u_dut0 (
      .gclk(gclk), .grst(grst), .gena(gena), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(z_gnt0), .gnt1(z_gnt1),
      .m_opa(z_opa), .m_opb(z_opb), .m_mul(zp2), .done0(z_done0), .done1(z_done1),
      .res0(z_res0), .res1(z_res1), .busy(z_busy));

   // Attached 2-stage multipliers, advanced by gena
   always @(posedge gclk) begin
      if (gena) begin
         p1  <= m_opa * m_opb;
         p2  <= p1;
         zp1 <= z_opa * z_opb;
         zp2 <= zp1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick;
      @(posedge gclk);
      #1;
   endtask

   initial begin
      grst = 1'b0; gena = 1'b1; req0 = 1'b1; req1 = 1'b0;
      a0 = 32'd3; b0 = 32'd5; a1 = 32'd0; b1 = 32'd0;
      tick; tick;
      #1;
      check("rst_gnt0", gnt0, 1'b0);
      check("rst_opa", m_opa, 32'h0);
      check("rst_done0", done0, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_res0", res0, 32'h0);
      check("rst_res1", res1, 32'h0);

      // Single op, first grant in the first cycle out of reset
      grst = 1'b1;
      #1;
      check("single_gnt0", gnt0, 1'b1);
      check("single_opa", m_opa, 32'd3);
      check("single_opb", m_opb, 32'd5);
      check("single_done0_c0", done0, 1'b0);
      tick; req0 = 1'b0; #1;
      check("single_gnt0_c1", gnt0, 1'b0);
      check("single_opa_c1", m_opa, 32'h0);
      check("single_busy_c1", busy, 1'b1);
      check("single_done0_c1", done0, 1'b0);
      tick; #1;
      check("single_done0_c2", done0, 1'b1);
      check("single_done1_c2", done1, 1'b0);
      tick; #1;
      check("single_done0_c3", done0, 1'b0);
      check("single_res0", res0, 32'd15);
      check("single_busy_c3", busy, 1'b0);

      // Contention from prio=0: grants 0,1,0,1 with dones 2 cycles later
      grst = 1'b0; tick; grst = 1'b1;
      a0 = 32'd2; b0 = 32'd3; a1 = 32'd4; b1 = 32'd5;
      for (int k = 0; k < 6; k++) begin
         req0 = (k < 4);
         req1 = (k < 4);
         #1;
         check($sformatf("rr_gnt0_k%0d", k), gnt0, (k < 4 && k % 2 == 0));
         check($sformatf("rr_gnt1_k%0d", k), gnt1, (k < 4 && k % 2 == 1));
         check($sformatf("rr_done0_k%0d", k), done0, (k >= 2 && k % 2 == 0));
         check($sformatf("rr_done1_k%0d", k), done1, (k >= 2 && k % 2 == 1));
         if (k == 1) check("rr_opa_t1", m_opa, 32'd4);
         tick;
      end
      #1;
      check("rr_res0", res0, 32'd6);
      check("rr_res1", res1, 32'd20);

      // Stall: grant, then four gena=0 cycles with thread 1 requesting
      req0 = 1'b1; a0 = 32'd6; b0 = 32'd7;
      #1;
      check("stall_gnt0", gnt0, 1'b1);
      tick;
      req0 = 1'b0; req1 = 1'b1; a1 = 32'd9; b1 = 32'd9; gena = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         #1;
         check($sformatf("stall_gnt1_c%0d", k), gnt1, 1'b0);
         check($sformatf("stall_done0_c%0d", k), done0, 1'b0);
         tick;
      end
      req1 = 1'b0; gena = 1'b1;
      #1;
      check("stall_done0_c5", done0, 1'b0);
      tick; #1;
      check("stall_done0_c6", done0, 1'b1);
      tick; #1;
      check("stall_done0_c7", done0, 1'b0);
      check("stall_res0", res0, 32'd42);

      // Wrap-around product
      req1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'd2;
      #1;
      check("wrap_gnt1", gnt1, 1'b1);
      tick; req1 = 1'b0;
      tick; #1;
      check("wrap_done1", done1, 1'b1);
      tick; #1;
      check("wrap_res1", res1, 32'hFFFF_FFFE);

      // Reset while an op is in flight
      req0 = 1'b1; a0 = 32'd5; b0 = 32'd5;
      #1;
      check("rmf_gnt0", gnt0, 1'b1);
      tick; req0 = 1'b0; grst = 1'b0; #1;
      check("rmf_busy_c1", busy, 1'b0);
      check("rmf_done0_c1", done0, 1'b0);
      tick; grst = 1'b1; #1;
      check("rmf_done0_c2", done0, 1'b0);
      check("rmf_busy_c2", busy, 1'b0);
      tick; #1;
      check("rmf_done0_c3", done0, 1'b0);
      check("rmf_res0", res0, 32'h0);
      check("rmf_res1", res1, 32'h0);
      req0 = 1'b1; req1 = 1'b1; a0 = 32'd1; b0 = 32'd1; a1 = 32'd2; b1 = 32'd2;
      #1;
      check("rmf_prio_gnt0", gnt0, 1'b1);
      check("rmf_prio_gnt1", gnt1, 1'b0);
      tick; req0 = 1'b0; req1 = 1'b0;
      tick; tick; tick;

      // MUL=0 instance forces results to zero
      req0 = 1'b1; a0 = 32'd7; b0 = 32'd9;
      #1;
      check("mul0_gnt0", z_gnt0, 1'b1);
      tick; req0 = 1'b0;
      tick; #1;
      check("mul0_done0", z_done0, 1'b1);
      check("mul1_done0", done0, 1'b1);
      tick; #1;
      check("mul0_res0", z_res0, 32'h0);
      check("mul1_res0", res0, 32'd63);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
